// File: rtl/mem_unit_if.sv
// Boot-stream, core memory-port and output-FIFO signals of mem_unit.
// slave = memory unit side, master = control unit / boot source / consumer side.
interface mem_unit_if;
  logic [7:0]  boot_data;
  logic        boot_valid;
  logic        boot_last;
  logic        boot_ready;
  logic        cpu_run;
  logic [7:0]  mem_addr;
  logic [15:0] mem_in;
  logic        mem_we;
  logic [15:0] mem_out;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_overflow;

  modport slave (
    input  boot_data, boot_valid, boot_last, mem_addr, mem_in, mem_we, out_ready,
    output boot_ready, cpu_run, mem_out, out_data, out_valid, out_overflow
  );

  modport master (
    output boot_data, boot_valid, boot_last, mem_addr, mem_in, mem_we, out_ready,
    input  boot_ready, cpu_run, mem_out, out_data, out_valid, out_overflow
  );
endinterface

// File: rtl/mem_unit.sv
// Unified program/data RAM filled by a byte-stream boot loader, with the top
// word mapped onto an 8-bit first-word fall-through output FIFO.
module mem_unit #(
  parameter int DEPTH      = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_unit_if.slave bus
);

  localparam int WAW = $clog2(DEPTH);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [WAW-1:0] IO_WORD   = WAW'(DEPTH - 1);
  // Pointer value of the 2*DEPTH-3'th byte: accepting it ends the boot.
  localparam logic [7:0]     AUTO_LAST = 8'(2 * DEPTH - 4);
  localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [7:0]      boot_ptr_r;
  logic            boot_ready_r;
  logic            cpu_run_r;
  logic [15:0]     ram_r [DEPTH];
  logic [7:0]      fifo_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            overflow_r;

  logic [WAW-1:0]  word_s;
  logic            io_sel_s;
  logic            boot_acc_s;
  logic            boot_done_s;
  logic            ram_we_s;
  logic            push_s;
  logic            push_ok_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic [7:0]      push_byte_s;

  // Decode of the core port, boot acceptance, FIFO handshake and next state.
  always_comb begin
    word_s      = bus.mem_addr[WAW:1];
    io_sel_s    = (word_s == IO_WORD);
    boot_acc_s  = (state_r == ST_BOOT) && bus.boot_valid && boot_ready_r;
    boot_done_s = boot_acc_s && (bus.boot_last || (boot_ptr_r == AUTO_LAST));
    full_s      = (count_r == FIFO_FULL);
    empty_s     = (count_r == {CW{1'b0}});
    pop_s       = !empty_s && bus.out_ready;
    ram_we_s    = (state_r == ST_RUN) && bus.mem_we && !io_sel_s;
    push_s      = (state_r == ST_RUN) && bus.mem_we && io_sel_s;
    push_ok_s   = push_s && (!full_s || pop_s);
    push_byte_s = bus.mem_addr[0] ? bus.mem_in[15:8] : bus.mem_in[7:0];
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: begin
        if (boot_done_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_BOOT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // Loader state, boot pointer and the registered core-release handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_BOOT;
      boot_ptr_r   <= 8'd0;
      boot_ready_r <= 1'b1;
      cpu_run_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      boot_ready_r <= (state_nxt_s == ST_BOOT);
      cpu_run_r    <= (state_nxt_s == ST_RUN);
      if (boot_acc_s) begin
        boot_ptr_r <= boot_ptr_r + 8'd1;
      end
    end
  end

  // RAM is deliberately not reset so a reboot keeps already-loaded contents.
  always_ff @(posedge clk) begin
    if (boot_acc_s) begin
      if (boot_ptr_r[0]) begin
        ram_r[boot_ptr_r[WAW:1]][15:8] <= bus.boot_data;
      end else begin
        ram_r[boot_ptr_r[WAW:1]][7:0]  <= bus.boot_data;
      end
    end else if (ram_we_s) begin
      ram_r[word_s] <= bus.mem_in;
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_r[wr_ptr_r] <= push_byte_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      if (push_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Zero-latency read port; the I/O word reads back FIFO status.
  always_comb begin
    if (io_sel_s) begin
      bus.mem_out = {13'd0, overflow_r, full_s, empty_s};
    end else begin
      bus.mem_out = ram_r[word_s];
    end
  end

  assign bus.boot_ready   = boot_ready_r;
  assign bus.cpu_run      = cpu_run_r;
  assign bus.out_data     = fifo_r[rd_ptr_r];
  assign bus.out_valid    = !empty_s;
  assign bus.out_overflow = overflow_r;

endmodule
